// File: rtl/fetch_unit_if.sv
// Handshake bundle between the fetch stage, instruction memory, decode and the ALU branch result.
// The master side is the fetch unit; the slave side is everything around it.
interface fetch_unit_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 9
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;

  logic               branch_en;
  logic               compres;
  logic [ADDR_W-1:0]  branch_target;

  logic               halt;
  logic               halted;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    output instr_valid,
    input  instr_ready,
    output instr,
    output instr_pc,
    input  branch_en,
    input  compres,
    input  branch_target,
    input  halt,
    output halted
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    input  instr_valid,
    output instr_ready,
    input  instr,
    input  instr_pc,
    output branch_en,
    output compres,
    output branch_target,
    output halt,
    input  halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/ack, hands words to decode over valid/ready,
// and redirects on taken branches, dropping any wrong-path response still in flight.
module fetch_unit #(
  parameter int              ADDR_W   = 16,
  parameter int              INSTR_W  = 9,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          clock,
  input  logic          reset_n,
  fetch_unit_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    HOLD    = 3'd2,
    DISCARD = 3'd3,
    HALT    = 3'd4
  } state_t;

  state_t             state_reg;
  logic [ADDR_W-1:0]  pc_reg;
  logic [ADDR_W-1:0]  req_addr_reg;
  logic [INSTR_W-1:0] instr_reg;
  logic [ADDR_W-1:0]  instr_pc_reg;
  logic               instr_valid_reg;
  logic               halted_reg;
  logic               halt_pend_reg;

  logic               taken;
  logic [ADDR_W-1:0]  pc_inc;

  assign taken  = bus.branch_en & bus.compres;
  assign pc_inc = pc_reg + ADDR_W'(1);

  // In DISCARD the PC may already point at the redirect target, so the
  // outstanding request address is kept separately to hold imem_addr stable.
  assign bus.imem_req    = (state_reg == REQ) || (state_reg == DISCARD);
  assign bus.imem_addr   = (state_reg == DISCARD) ? req_addr_reg : pc_reg;
  assign bus.instr       = instr_reg;
  assign bus.instr_pc    = instr_pc_reg;
  assign bus.instr_valid = instr_valid_reg;
  assign bus.halted      = halted_reg;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      pc_reg          <= RESET_PC;
      req_addr_reg    <= RESET_PC;
      instr_reg       <= '0;
      instr_pc_reg    <= '0;
      instr_valid_reg <= 1'b0;
      halted_reg      <= 1'b0;
      halt_pend_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg <= REQ;
        end

        REQ: begin
          if (bus.halt) begin
            // Halt beats any branch; the open request must still be completed.
            if (bus.imem_ack) begin
              state_reg  <= HALT;
              halted_reg <= 1'b1;
            end else begin
              state_reg     <= DISCARD;
              req_addr_reg  <= pc_reg;
              halt_pend_reg <= 1'b1;
            end
          end else if (bus.imem_ack) begin
            if (taken) begin
              pc_reg    <= bus.branch_target;
              state_reg <= REQ;
            end else begin
              instr_reg       <= bus.imem_rdata;
              instr_pc_reg    <= pc_reg;
              instr_valid_reg <= 1'b1;
              pc_reg          <= pc_inc;
              state_reg       <= HOLD;
            end
          end else if (taken) begin
            req_addr_reg <= pc_reg;
            pc_reg       <= bus.branch_target;
            state_reg    <= DISCARD;
          end
        end

        HOLD: begin
          if (bus.halt) begin
            instr_valid_reg <= 1'b0;
            state_reg       <= HALT;
            halted_reg      <= 1'b1;
          end else if (taken) begin
            pc_reg          <= bus.branch_target;
            instr_valid_reg <= 1'b0;
            state_reg       <= REQ;
          end else if (bus.instr_ready) begin
            instr_valid_reg <= 1'b0;
            state_reg       <= REQ;
          end
        end

        DISCARD: begin
          if (bus.halt || halt_pend_reg) begin
            if (bus.imem_ack) begin
              state_reg     <= HALT;
              halted_reg    <= 1'b1;
              halt_pend_reg <= 1'b0;
            end else begin
              halt_pend_reg <= 1'b1;
            end
          end else begin
            if (taken) begin
              pc_reg <= bus.branch_target;
            end
            if (bus.imem_ack) begin
              state_reg <= REQ;
            end
          end
        end

        HALT: begin
          instr_valid_reg <= 1'b0;
          halted_reg      <= 1'b1;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stalls, branch flushes, PC wrap, halt and reset.
module tb_fetch_unit;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  fetch_unit_if #(.ADDR_W(16), .INSTR_W(9)) bus ();

  fetch_unit #(
    .ADDR_W  (16),
    .INSTR_W (9),
    .RESET_PC(16'h0000)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory contents: a fixed scramble of the address so each word is distinct.
  function automatic logic [8:0] mem_word(input logic [15:0] a);
    return a[8:0] ^ 9'h0A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    bus.instr_ready = 1'b0;
    bus.branch_en = 1'b0;
    bus.compres = 1'b0;
    bus.branch_target = '0;
    bus.halt = 1'b0;

    // Reset
    tick();
    tick();
    check("rst_req", bus.imem_req, 1'b0);
    check("rst_valid", bus.instr_valid, 1'b0);
    check("rst_instr", bus.instr, 9'h000);
    check("rst_instr_pc", bus.instr_pc, 16'h0000);
    check("rst_halted", bus.halted, 1'b0);
    reset_n = 1'b1;
    tick();

    // Sequential fetch: same-cycle ack, decode always ready
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("seq_req", bus.imem_req, 1'b1);
      check("seq_addr", bus.imem_addr, 16'(k));
      check("seq_valid_low", bus.instr_valid, 1'b0);
      bus.imem_ack = 1'b1;
      bus.imem_rdata = mem_word(16'(k));
      tick();
      bus.imem_ack = 1'b0;
      check("seq_valid", bus.instr_valid, 1'b1);
      check("seq_instr_pc", bus.instr_pc, 16'(k));
      check("seq_instr", bus.instr, mem_word(16'(k)));
      check("seq_req_off", bus.imem_req, 1'b0);
      $display("fetch pc=%04h instr=%03h", bus.instr_pc, bus.instr);
      tick();
    end

    // Slow memory (3-cycle wait) and a stalled decode
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("wait_req", bus.imem_req, 1'b1);
      check("wait_addr", bus.imem_addr, 16'h0004);
      check("wait_valid", bus.instr_valid, 1'b0);
      tick();
    end
    bus.imem_ack = 1'b1;
    bus.imem_rdata = mem_word(16'h0004);
    tick();
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 9'h1FF;
    for (int i = 0; i < 4; i++) begin
      check("stall_valid", bus.instr_valid, 1'b1);
      check("stall_instr", bus.instr, mem_word(16'h0004));
      check("stall_instr_pc", bus.instr_pc, 16'h0004);
      check("stall_req", bus.imem_req, 1'b0);
      tick();
    end
    $display("fetch pc=%04h instr=%03h", bus.instr_pc, bus.instr);
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    check("noskip_addr", bus.imem_addr, 16'h0005);
    check("noskip_valid", bus.instr_valid, 1'b0);

    // Branch while holding the instruction from 0x0005
    bus.imem_ack = 1'b1;
    bus.imem_rdata = mem_word(16'h0005);
    tick();
    bus.imem_ack = 1'b0;
    check("hold5_pc", bus.instr_pc, 16'h0005);
    bus.branch_en = 1'b1;
    bus.compres = 1'b0;
    bus.branch_target = 16'h0040;
    tick();
    check("nt_valid", bus.instr_valid, 1'b1);
    check("nt_pc", bus.instr_pc, 16'h0005);
    check("nt_req", bus.imem_req, 1'b0);
    bus.compres = 1'b1;
    bus.instr_ready = 1'b1;
    tick();
    bus.branch_en = 1'b0;
    bus.compres = 1'b0;
    bus.instr_ready = 1'b0;
    check("brhold_valid", bus.instr_valid, 1'b0);
    check("brhold_req", bus.imem_req, 1'b1);
    check("brhold_addr", bus.imem_addr, 16'h0040);
    $display("redirect to %04h", bus.imem_addr);

    // Branch to 0x0007 with 0x0040 outstanding, then to 0x0100 with 0x0007 outstanding
    bus.branch_en = 1'b1;
    bus.compres = 1'b1;
    bus.branch_target = 16'h0007;
    tick();
    bus.branch_en = 1'b0;
    bus.compres = 1'b0;
    check("disc40_addr", bus.imem_addr, 16'h0040);
    check("disc40_req", bus.imem_req, 1'b1);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = mem_word(16'h0040);
    tick();
    bus.imem_ack = 1'b0;
    check("disc40_valid", bus.instr_valid, 1'b0);
    check("req7_addr", bus.imem_addr, 16'h0007);
    bus.branch_en = 1'b1;
    bus.compres = 1'b1;
    bus.branch_target = 16'h0100;
    tick();
    bus.branch_en = 1'b0;
    bus.compres = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("disc7_addr", bus.imem_addr, 16'h0007);
      check("disc7_req", bus.imem_req, 1'b1);
      check("disc7_valid", bus.instr_valid, 1'b0);
      if (i == 1) begin
        bus.imem_ack = 1'b1;
        bus.imem_rdata = mem_word(16'h0007);
      end
      tick();
    end
    bus.imem_ack = 1'b0;
    check("drop7_valid", bus.instr_valid, 1'b0);
    check("req100_addr", bus.imem_addr, 16'h0100);
    check("req100_req", bus.imem_req, 1'b1);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = mem_word(16'h0100);
    tick();
    bus.imem_ack = 1'b0;
    check("f100_valid", bus.instr_valid, 1'b1);
    check("f100_pc", bus.instr_pc, 16'h0100);
    check("f100_instr", bus.instr, mem_word(16'h0100));
    $display("fetch pc=%04h instr=%03h", bus.instr_pc, bus.instr);
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    check("req101_addr", bus.imem_addr, 16'h0101);

    // Branch to 0xFFFF in the same cycle as the ack for 0x0101
    bus.branch_en = 1'b1;
    bus.compres = 1'b1;
    bus.branch_target = 16'hFFFF;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = mem_word(16'h0101);
    tick();
    bus.branch_en = 1'b0;
    bus.compres = 1'b0;
    bus.imem_ack = 1'b0;
    check("brack_valid", bus.instr_valid, 1'b0);
    check("brack_addr", bus.imem_addr, 16'hFFFF);

    // PC wrap
    bus.imem_ack = 1'b1;
    bus.imem_rdata = mem_word(16'hFFFF);
    bus.instr_ready = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    check("ffff_pc", bus.instr_pc, 16'hFFFF);
    check("ffff_instr", bus.instr, mem_word(16'hFFFF));
    $display("fetch pc=%04h instr=%03h", bus.instr_pc, bus.instr);
    tick();
    bus.instr_ready = 1'b0;
    check("wrap_addr", bus.imem_addr, 16'h0000);
    check("wrap_req", bus.imem_req, 1'b1);

    // Halt together with a taken branch while holding
    bus.imem_ack = 1'b1;
    bus.imem_rdata = mem_word(16'h0000);
    tick();
    bus.imem_ack = 1'b0;
    bus.halt = 1'b1;
    bus.branch_en = 1'b1;
    bus.compres = 1'b1;
    bus.branch_target = 16'h0200;
    tick();
    bus.halt = 1'b0;
    bus.branch_en = 1'b0;
    bus.compres = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("halt_halted", bus.halted, 1'b1);
      check("halt_req", bus.imem_req, 1'b0);
      check("halt_valid", bus.instr_valid, 1'b0);
      tick();
    end
    $display("halted");

    // Reset exits HALT, fetch restarts at RESET_PC
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("rst2_halted", bus.halted, 1'b0);
    check("rst2_req", bus.imem_req, 1'b0);
    tick();
    check("restart_req", bus.imem_req, 1'b1);
    check("restart_addr", bus.imem_addr, 16'h0000);

    // Halt with a request outstanding: request completes, data dropped
    bus.halt = 1'b1;
    tick();
    bus.halt = 1'b0;
    check("hreq_req", bus.imem_req, 1'b1);
    check("hreq_addr", bus.imem_addr, 16'h0000);
    check("hreq_halted", bus.halted, 1'b0);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = mem_word(16'h0000);
    tick();
    bus.imem_ack = 1'b0;
    check("hreq_done_halted", bus.halted, 1'b1);
    check("hreq_done_req", bus.imem_req, 1'b0);
    check("hreq_done_valid", bus.instr_valid, 1'b0);
    $display("halted after outstanding request");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 16-bit multicycle core. It owns the program counter, issues requests to instruction memory over a req/ack handshake, and presents each fetched instruction to decode over a valid/ready handshake. It sits directly upstream of decode/ALU and consumes the ALU's `compres` branch result to redirect the PC, flushing any wrong-path fetch.

## Interface
Parameters:
- `ADDR_W`, 16, PC / instruction address width
- `INSTR_W`, 9, instruction word width
- `RESET_PC`, 0, PC value loaded on reset

Ports:
- `clock`  in  1  single clock, rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `imem_req`  out  1  fetch request to instruction memory
- `imem_addr`  out  ADDR_W  fetch address, equals current PC while `imem_req`=1
- `imem_ack`  in  1  memory response valid; `imem_rdata` is sampled on the same edge
- `imem_rdata`  in  INSTR_W  fetched instruction word
- `instr_valid`  out  1  `instr`/`instr_pc` hold a fetched instruction
- `instr_ready`  in  1  decode accepts the instruction
- `instr`  out  INSTR_W  instruction to decode
- `instr_pc`  out  ADDR_W  address the instruction was fetched from
- `branch_en`  in  1  a branch instruction resolves this cycle
- `compres`  in  1  ALU comparison result; taken when `branch_en`=1 and `compres`=1
- `branch_target`  in  ADDR_W  redirect address, sampled when taken
- `halt`  in  1  decode has seen the halt instruction
- `halted`  out  1  fetch is stopped

## Operation
- States: IDLE, REQ, HOLD, DISCARD, HALT.
- Reset (`reset_n`=0 at a rising edge): state=IDLE, pc=`RESET_PC`, `instr_valid`=0, `instr`=0, `instr_pc`=0, `halted`=0. `imem_req`=0 during reset and while in IDLE.
- IDLE -> REQ unconditionally.
- REQ: `imem_req`=1, `imem_addr`=pc. On `imem_ack`: `instr`<=`imem_rdata`, `instr_pc`<=pc, `instr_valid`<=1, pc<=pc+1 (modulo 2^ADDR_W; 16'hFFFF wraps to 0), -> HOLD. Without ack: remain in REQ; `imem_addr` held stable. A request is never withdrawn before ack.
- HOLD: `instr_valid`=1, `instr` and `instr_pc` stable. On `instr_ready`: `instr_valid`<=0, -> REQ.
- Taken branch (`branch_en`&`compres`), evaluated in REQ, HOLD, or DISCARD:
  - pc<=`branch_target`; `instr_valid`<=0 (flush, even when `instr_ready`=1 in the same cycle).
  - In HOLD -> REQ.
  - In REQ with `imem_ack`=1 the same cycle: response dropped, -> REQ.
  - In REQ without ack -> DISCARD.
  - In DISCARD: pc retargeted; state stays DISCARD.
- DISCARD: `imem_req`=1, `imem_addr` = the address of the outstanding request, held stable. On `imem_ack`: data dropped, -> REQ at pc.
- Not-taken branch (`branch_en`=1, `compres`=0): no effect.
- `halt`=1 (any state except IDLE):
  - With no outstanding request (HOLD): -> HALT next edge, `instr_valid`<=0.
  - In REQ or DISCARD: the request is completed, its data is dropped, then -> HALT.
- Halt and a taken branch in the same cycle: halt wins and the branch is ignored.
- HALT: `imem_req`=0, `instr_valid`=0, `halted`=1. Only `reset_n` exits.
- Reset asserted mid-request: all state returns to its reset values on that edge. The memory must tolerate the request being abandoned.

## Timing
- Registered outputs: `instr`, `instr_valid`, `instr_pc`, `halted`. `imem_req` and `imem_addr` are decoded from state and pc and carry no combinational path from any input.
- First request: the edge that samples `reset_n`=1 enters IDLE. `imem_req`=1 from the following cycle.
- Fetch latency: `instr_valid` rises one cycle after the ack edge.
- Peak throughput: one instruction per 2 cycles (single-cycle ack, `instr_ready` held high).
- Redirect: the first request to `branch_target` appears the cycle after the taken-branch edge, or the cycle after the discarded ack.

## Test plan
- Reset `RESET_PC`=0, memory acks same cycle, `instr_ready`=1 -> `imem_addr` sequence 0,1,2,3 on alternate cycles; `instr_pc` 0,1,2,3 with matching `instr`.
- Memory ack delayed 3 cycles, `instr_ready`=0 for 4 cycles -> `imem_addr`/`imem_req` stable until ack; `instr_valid` and `instr` stable until ready; no PC skip.
- Taken branch to 0x0040 while in HOLD at pc 0x0005 -> `instr_valid` drops next cycle; next `imem_addr`=0x0040; instruction 0x0005 never accepted.
- Taken branch to 0x0100 while request to 0x0007 is outstanding (ack 2 cycles later) -> 0x0007 data dropped, `instr_valid` stays 0; next request is 0x0100.
- PC at 0xFFFF -> next request address 0x0000.
- `halt` and taken branch in the same cycle -> `halted`=1, no further `imem_req`; `reset_n`=0 for one edge -> `halted`=0 and fetch restarts at `RESET_PC`.
